// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one word-addressed, fixed-latency memory between instruction
// fetch (IF), load/store (LS) and a debug/loader port (DBG). One transaction is in flight at a
// time: IDLE -> GRANT (mem_en strobe) -> WAIT (MEM_LAT cycles) -> RESP (rvalid to the owner).
//
// Ports:
//   clk, RN               clock, synchronous active-high reset
//   if_*                  IF read requester (req/addr in, gnt/rvalid/rdata out)
//   ls_*                  LS load/store requester (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   dbg_*                 DBG load/store requester (same shape as LS)
//   mem_*                 memory side: en/we/addr/wdata out, rdata in (valid MEM_LAT after en)
//   pipe_stall            pipeline hold while IF/LS requests or transactions are pending
module rv32i_mem_arbiter #(
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          RN,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          pipe_stall
);

    localparam logic [3:0] LatInit   = 4'(MEM_LAT);
    localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StGrant, StWait, StResp} state_e;
    typedef enum logic [1:0] {OwnNone, OwnIf, OwnLs, OwnDbg} owner_e;

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    owner_e          win;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      starve_q, starve_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   ls_rdata_q, ls_rdata_d;
    logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;

    // Fixed priority, except a starved DBG overrides everyone.
    always_comb begin
        win = OwnNone;
        if (dbg_req && (starve_q == StarveLim)) begin
            win = OwnDbg;
        end else if (ls_req) begin
            win = OwnLs;
        end else if (if_req) begin
            win = OwnIf;
        end else if (dbg_req) begin
            win = OwnDbg;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        unique case (state_q)
            StIdle, StResp: begin
                if (win == OwnNone) begin
                    state_d = StIdle;
                end else begin
                    state_d = StGrant;
                    owner_d = win;
                    unique case (win)
                        OwnIf: begin
                            we_d    = 1'b0;
                            addr_d  = if_addr;
                            wdata_d = '0;
                        end
                        OwnLs: begin
                            we_d    = ls_we;
                            addr_d  = ls_addr;
                            wdata_d = ls_wdata;
                        end
                        OwnDbg: begin
                            we_d    = dbg_we;
                            addr_d  = dbg_addr;
                            wdata_d = dbg_wdata;
                        end
                        default: ;
                    endcase
                    if (win == OwnDbg) begin
                        starve_d = '0;
                    end else if (dbg_req && (starve_q != StarveLim)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            StGrant: begin
                cnt_d   = LatInit;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                // Counter at 1 marks cycle GRANT+MEM_LAT, when mem_rdata is valid.
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    if (!we_q) begin
                        unique case (owner_q)
                            OwnIf:   if_rdata_d  = mem_rdata;
                            OwnLs:   ls_rdata_d  = mem_rdata;
                            OwnDbg:  dbg_rdata_d = mem_rdata;
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (!dbg_req) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (RN) begin
            state_q     <= StIdle;
            owner_q     <= OwnNone;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            starve_q    <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Handshake outputs decode registered state only; no req-to-gnt path.
    always_comb begin
        mem_en     = (state_q == StGrant);
        mem_we     = we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        if_gnt     = mem_en && (owner_q == OwnIf);
        ls_gnt     = mem_en && (owner_q == OwnLs);
        dbg_gnt    = mem_en && (owner_q == OwnDbg);
        if_rvalid  = (state_q == StResp) && (owner_q == OwnIf);
        ls_rvalid  = (state_q == StResp) && (owner_q == OwnLs);
        dbg_rvalid = (state_q == StResp) && (owner_q == OwnDbg);
        if_rdata   = if_rdata_q;
        ls_rdata   = ls_rdata_q;
        dbg_rdata  = dbg_rdata_q;
        pipe_stall = if_req || ls_req ||
                     (((owner_q == OwnIf) || (owner_q == OwnLs)) &&
                      ((state_q == StGrant) || (state_q == StWait)));
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
Single-port memory arbiter and sequencer for the rv32i core. It shares one word-addressed memory between three requesters:
- instruction fetch (IF)
- load/store stage (LS)
- debug/loader port (DBG), used for program load and inspection.

It serialises accesses, tracks the fixed memory read latency, returns read data to the owning requester, and raises a stall for the pipeline while its accesses are pending.

Parameters:
AW, 5, word address width (32-word memory)
DW, 32, data width
MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata (legal range 1..15)
STARVE_MAX, 4, consecutive lost arbitrations before DBG is forced to win (legal range 1..15)

Ports:
clk  input  1  clock, all logic on posedge
RN  input  1  reset, synchronous, active-high
if_req  input  1  IF read request, held until if_gnt
if_addr  input  AW  IF word address
if_gnt  output  1  one-cycle accept pulse
if_rvalid  output  1  one-cycle completion pulse
if_rdata  output  DW  IF read data, valid with if_rvalid
ls_req  input  1  LS request, held until ls_gnt
ls_we  input  1  1 = store, 0 = load
ls_addr  input  AW  LS word address
ls_wdata  input  DW  store data
ls_gnt  output  1  accept pulse
ls_rvalid  output  1  completion pulse (loads and stores)
ls_rdata  output  DW  load data
dbg_req  input  1  DBG request, held until dbg_gnt
dbg_we  input  1  DBG write enable
dbg_addr  input  AW  DBG address
dbg_wdata  input  DW  DBG write data
dbg_gnt  output  1  accept pulse
dbg_rvalid  output  1  completion pulse
dbg_rdata  output  DW  DBG read data
mem_en  output  1  memory access strobe (one cycle per transaction)
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after mem_en
pipe_stall  output  1  pipeline hold request

Behaviour:
- Reset (RN high at posedge):
  - state to IDLE, latency counter and starve counter to 0.
  - All outputs go to 0, including the rdata outputs and mem_* outputs.
  - An in-flight transaction is dropped: no rvalid is issued. A write already strobed still completes in memory.
- FSM states: IDLE, GRANT, WAIT, RESP. Exactly one transaction is outstanding at a time.
- Arbitration is evaluated in IDLE and RESP whenever any req is high. Order of precedence:
  - DBG wins if dbg_req is high and starve count == STARVE_MAX.
  - Otherwise LS wins, then IF, then DBG.
  - The winner's id, we, addr and wdata are latched. Next state is GRANT.
  - If no req is high: IDLE stays IDLE; RESP goes to IDLE.
- GRANT (one cycle):
  - mem_en = 1; mem_we/addr/wdata come from the latched request.
  - The owner's gnt = 1. IF transactions always have we = 0.
  - Latency counter is loaded with MEM_LAT. Next state is WAIT.
- WAIT:
  - Counter decrements each cycle.
  - mem_en = 0; mem_addr, mem_wdata and mem_we hold their values.
  - In the cycle the counter reaches 1 (cycle GRANT+MEM_LAT), mem_rdata is captured. Next state is RESP.
- RESP (one cycle):
  - The owner's rvalid = 1.
  - The owner's rdata is updated only for reads. On writes, rdata holds its previous value.
  - Arbitration runs this same cycle, so back-to-back transactions occur every MEM_LAT+2 cycles.
- Latency: a req first seen in IDLE at cycle T gives gnt at T+1 and rvalid at T+2+MEM_LAT.
- Starve counter:
  - Increments (saturating at STARVE_MAX) at each arbitration where dbg_req is high and DBG loses.
  - Clears when DBG is granted or when dbg_req is low.
- A requester deasserting req before gnt is a protocol error. Behaviour in that case is not defined.
- A new req from the same requester may arrive during its own RESP and is arbitrated in that cycle.
- pipe_stall is combinational: if_req | ls_req | (owner ∈ {IF, LS} and state ∈ {GRANT, WAIT}).
  - It is 0 during RESP unless a new IF or LS req is present.
- All other outputs are registered or decoded from state only. There is no combinational path from req to gnt.

Test Plan:
- Reset, then if_req=1 with if_addr=3 at cycle T, MEM_LAT=2 → mem_en=1 and if_gnt=1 at T+1; mem_addr=3; if_rvalid=1 with if_rdata=mem[3] at T+4; pipe_stall=1 from T through T+3.
- ls_req (store, addr 7, wdata 0xDEADBEEF) and if_req raised together → LS granted first with mem_we=1; ls_rvalid pulses while ls_rdata holds its old value; IF is granted in LS's RESP cycle; a later IF read of addr 7 returns 0xDEADBEEF.
- dbg_req held high while ls_req and if_req alternate continuously → DBG loses 4 arbitrations, then wins the 5th; starve count returns to 0.
- Back-to-back if_req held high across RESP → gnt pulses spaced exactly MEM_LAT+2 = 4 cycles apart, with no IDLE cycle between transactions.
- RN asserted during WAIT of a DBG read → next cycle all outputs are 0 and state is IDLE; dbg_rvalid never pulses; a new if_req is served normally afterward.
- Reconfigure MEM_LAT=1 and issue one LS load → ls_rvalid arrives 3 cycles after ls_req with the correct data.
